// File: rtl/ahb_op_sequencer.sv
// ---------------------------------------------------------------------------
// ahb_op_sequencer
// AHB-Lite master that turns one compute command into the fixed transfer
// sequence: write operand A, write operand B, write opcode, read result.
// The result (or an error indication) is returned on a valid/ready channel.
//
// Ports:
//   HCLK, HRESETn          clock, asynchronous reset (active-high)
//   cmd_valid/cmd_ready    command handshake; cmd_unit/op/a/b are its payload
//   rsp_valid/rsp_ready    response handshake; rsp_data/rsp_err its payload
//   busy                   high whenever the sequencer is not idle
//   o_H*                   AHB-Lite master address/control/write-data outputs
//   i_HRDATA/HRESP/HREADY  AHB-Lite slave read data, response and ready
// ---------------------------------------------------------------------------
module ahb_op_sequencer #(
   parameter logic [31:0] ALU_BASE = 32'h4000_0000,
   parameter logic [31:0] MUL_BASE = 32'h4001_0000,
   parameter logic [7:0]  OFS_A    = 8'h00,
   parameter logic [7:0]  OFS_B    = 8'h04,
   parameter logic [7:0]  OFS_CMD  = 8'h08,
   parameter logic [7:0]  OFS_RES  = 8'h0C
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_unit,
   input  logic [3:0]  cmd_op,
   input  logic [31:0] cmd_a,
   input  logic [31:0] cmd_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   output logic        busy,
   output logic [31:0] o_HADDR,
   output logic [31:0] o_HWDATA,
   output logic        o_HWRITE,
   output logic [2:0]  o_HSIZE,
   output logic [2:0]  o_HBURST,
   output logic [1:0]  o_HTRANS,
   input  logic [31:0] i_HRDATA,
   input  logic [1:0]  i_HRESP,
   input  logic        i_HREADY
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ADDR = 2'b01,
      ST_DATA = 2'b10,
      ST_RESP = 2'b11
   } state_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HRESP_ERROR   = 2'b01;

   // Address of the transfer selected by the step counter in the chosen window.
   function automatic logic [31:0] step_addr(input logic unit, input logic [1:0] step);
      logic [31:0] base_v;
      logic [7:0]  ofs_v;
      base_v = unit ? MUL_BASE : ALU_BASE;
      case (step)
         2'd0:    ofs_v = OFS_A;
         2'd1:    ofs_v = OFS_B;
         2'd2:    ofs_v = OFS_CMD;
         2'd3:    ofs_v = OFS_RES;
         default: ofs_v = OFS_A;
      endcase
      return base_v + {24'h00_0000, ofs_v};
   endfunction

   // Write data for a step; the result read carries no write data.
   function automatic logic [31:0] step_wdata(input logic [1:0] step, input logic [31:0] a,
                                              input logic [31:0] b, input logic [3:0] op);
      logic [31:0] d_v;
      case (step)
         2'd0:    d_v = a;
         2'd1:    d_v = b;
         2'd2:    d_v = {28'h000_0000, op};
         2'd3:    d_v = 32'h0000_0000;
         default: d_v = 32'h0000_0000;
      endcase
      return d_v;
   endfunction

   state_t      state_r, state_s;
   logic [1:0]  step_r, step_s, next_step_s;
   logic        unit_r, unit_s;
   logic [3:0]  op_r, op_s;
   logic [31:0] a_r, a_s, b_r, b_s;
   logic        cmd_ready_r, cmd_ready_s;
   logic        rsp_valid_r, rsp_valid_s;
   logic [31:0] rsp_data_r, rsp_data_s;
   logic        rsp_err_r, rsp_err_s;
   logic        busy_r, busy_s;
   logic [1:0]  htrans_r, htrans_s;
   logic [31:0] haddr_r, haddr_s;
   logic [31:0] hwdata_r, hwdata_s;
   logic        hwrite_r, hwrite_s;
   logic        err_now_s;

   // State, captured command and every output register.
   always_ff @(posedge HCLK or posedge HRESETn) begin
      if (HRESETn) begin
         state_r     <= ST_IDLE;
         step_r      <= 2'd0;
         unit_r      <= 1'b0;
         op_r        <= 4'h0;
         a_r         <= 32'h0000_0000;
         b_r         <= 32'h0000_0000;
         cmd_ready_r <= 1'b1;
         rsp_valid_r <= 1'b0;
         rsp_data_r  <= 32'h0000_0000;
         rsp_err_r   <= 1'b0;
         busy_r      <= 1'b0;
         htrans_r    <= HTRANS_IDLE;
         haddr_r     <= 32'h0000_0000;
         hwdata_r    <= 32'h0000_0000;
         hwrite_r    <= 1'b0;
      end else begin
         state_r     <= state_s;
         step_r      <= step_s;
         unit_r      <= unit_s;
         op_r        <= op_s;
         a_r         <= a_s;
         b_r         <= b_s;
         cmd_ready_r <= cmd_ready_s;
         rsp_valid_r <= rsp_valid_s;
         rsp_data_r  <= rsp_data_s;
         rsp_err_r   <= rsp_err_s;
         busy_r      <= busy_s;
         htrans_r    <= htrans_s;
         haddr_r     <= haddr_s;
         hwdata_r    <= hwdata_s;
         hwrite_r    <= hwrite_s;
      end
   end

   // Next-state and next-output logic; every register holds unless changed.
   always_comb begin
      state_s     = state_r;
      step_s      = step_r;
      unit_s      = unit_r;
      op_s        = op_r;
      a_s         = a_r;
      b_s         = b_r;
      cmd_ready_s = cmd_ready_r;
      rsp_valid_s = rsp_valid_r;
      rsp_data_s  = rsp_data_r;
      rsp_err_s   = rsp_err_r;
      busy_s      = busy_r;
      htrans_s    = htrans_r;
      haddr_s     = haddr_r;
      hwdata_s    = hwdata_r;
      hwrite_s    = hwrite_r;
      next_step_s = step_r + 2'd1;
      err_now_s   = (i_HRESP == HRESP_ERROR);

      case (state_r)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready_r) begin
               unit_s      = cmd_unit;
               op_s        = cmd_op;
               a_s         = cmd_a;
               b_s         = cmd_b;
               step_s      = 2'd0;
               cmd_ready_s = 1'b0;
               busy_s      = 1'b1;
               htrans_s    = HTRANS_NONSEQ;
               haddr_s     = step_addr(cmd_unit, 2'd0);
               hwrite_s    = 1'b1;
               state_s     = ST_ADDR;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ADDR: begin
            // Address phase accepted: drop to IDLE transfers and present write data.
            if (i_HREADY) begin
               htrans_s = HTRANS_IDLE;
               hwdata_s = step_wdata(step_r, a_r, b_r, op_r);
               state_s  = ST_DATA;
            end else begin
               state_s = ST_ADDR;
            end
         end
         ST_DATA: begin
            // An ERROR may show in the first (wait) cycle of the two-cycle response.
            if (err_now_s) begin
               rsp_err_s  = 1'b1;
               rsp_data_s = 32'h0000_0000;
            end else begin
               rsp_err_s = rsp_err_r;
            end
            if (i_HREADY) begin
               if (err_now_s || rsp_err_r) begin
                  rsp_err_s   = 1'b1;
                  rsp_data_s  = 32'h0000_0000;
                  rsp_valid_s = 1'b1;
                  state_s     = ST_RESP;
               end else if (step_r == 2'd3) begin
                  rsp_data_s  = i_HRDATA;
                  rsp_valid_s = 1'b1;
                  state_s     = ST_RESP;
               end else begin
                  step_s   = next_step_s;
                  htrans_s = HTRANS_NONSEQ;
                  haddr_s  = step_addr(unit_r, next_step_s);
                  hwrite_s = (next_step_s != 2'd3);
                  state_s  = ST_ADDR;
               end
            end else begin
               state_s = ST_DATA;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_s = 1'b0;
               rsp_err_s   = 1'b0;
               step_s      = 2'd0;
               cmd_ready_s = 1'b1;
               busy_s      = 1'b0;
               state_s     = ST_IDLE;
            end else begin
               state_s = ST_RESP;
            end
         end
         default: begin
            state_s     = ST_IDLE;
            step_s      = 2'd0;
            cmd_ready_s = 1'b1;
            rsp_valid_s = 1'b0;
            busy_s      = 1'b0;
            htrans_s    = HTRANS_IDLE;
         end
      endcase
   end

   assign cmd_ready = cmd_ready_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_data  = rsp_data_r;
   assign rsp_err   = rsp_err_r;
   assign busy      = busy_r;
   assign o_HADDR   = haddr_r;
   assign o_HWDATA  = hwdata_r;
   assign o_HWRITE  = hwrite_r;
   assign o_HTRANS  = htrans_r;
   assign o_HSIZE   = 3'b010;
   assign o_HBURST  = 3'b000;

endmodule

// File: tb/tb_ahb_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ahb_op_sequencer
// Directed and randomized commands against an AHB-Lite slave model with
// configurable wait states, address-phase stalls and two-cycle ERROR
// responses. Expected transfers, latency and results come from the
// command-level rules (base + 4*step, 2 cycles per transfer plus waits).
// ---------------------------------------------------------------------------
module tb_ahb_op_sequencer;

   localparam logic [31:0] ALU_BASE = 32'h4000_0000;
   localparam logic [31:0] MUL_BASE = 32'h4001_0000;

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b1;
   logic        cmd_valid, cmd_ready, cmd_unit;
   logic [3:0]  cmd_op;
   logic [31:0] cmd_a, cmd_b;
   logic        rsp_valid, rsp_ready, rsp_err, busy;
   logic [31:0] rsp_data;
   logic [31:0] o_HADDR, o_HWDATA, i_HRDATA;
   logic        o_HWRITE, i_HREADY;
   logic [2:0]  o_HSIZE, o_HBURST;
   logic [1:0]  o_HTRANS, i_HRESP;

   ahb_op_sequencer dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_unit(cmd_unit),
      .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_err(rsp_err), .busy(busy),
      .o_HADDR(o_HADDR), .o_HWDATA(o_HWDATA), .o_HWRITE(o_HWRITE),
      .o_HSIZE(o_HSIZE), .o_HBURST(o_HBURST), .o_HTRANS(o_HTRANS),
      .i_HRDATA(i_HRDATA), .i_HRESP(i_HRESP), .i_HREADY(i_HREADY)
   );

   always #5 HCLK = ~HCLK;

   int errors = 0;
   int checks = 0;

   // slave configuration and state
   int          cfg_waits [4];
   int          cfg_err_step;
   int          astall_left;
   bit          dp_active, dp_write, dp_first, dp_is_err, stalling;
   int          dp_wait_left, dp_err_cnt;
   logic [31:0] dp_addr, dp_hwdata, stall_addr;
   logic [31:0] s_a, s_b;
   logic [31:0] t_addr [$];
   logic        t_write [$];
   logic [31:0] t_wdata [$];
   int          nonseq_cycles, unstable_cnt, bad_htrans;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] slave_result();
      return (dp_addr[31:16] == MUL_BASE[31:16]) ? s_a * s_b : s_a + s_b;
   endfunction

   function automatic void finish_dp();
      t_addr.push_back(dp_addr);
      t_write.push_back(dp_write);
      t_wdata.push_back(o_HWDATA);
      if (dp_write && dp_addr[3:2] == 2'd0) s_a = o_HWDATA;
      if (dp_write && dp_addr[3:2] == 2'd1) s_b = o_HWDATA;
      dp_active = 1'b0;
   endfunction

   // AHB slave: decides at each falling edge what the next rising edge sees
   task automatic slave_loop();
      forever begin
         @(negedge HCLK);
         if (HRESETn) begin
            dp_active = 1'b0; stalling = 1'b0;
            i_HREADY = 1'b1; i_HRESP = 2'b00; i_HRDATA = 32'h0;
         end else begin
            if (!(o_HTRANS inside {2'b00, 2'b10})) bad_htrans++;
            if (o_HTRANS == 2'b10 && (dp_active || rsp_valid)) bad_htrans++;
            if (dp_active) begin
               if (dp_first) begin dp_hwdata = o_HWDATA; dp_first = 1'b0; end
               else if (o_HWDATA !== dp_hwdata) unstable_cnt++;
               i_HRDATA = $urandom;
               if (dp_is_err) begin
                  i_HRESP = 2'b01;
                  if (dp_err_cnt == 0) begin i_HREADY = 1'b0; dp_err_cnt = 1; end
                  else begin i_HREADY = 1'b1; finish_dp(); end
               end else if (dp_wait_left > 0) begin
                  i_HREADY = 1'b0; i_HRESP = 2'b00; dp_wait_left--;
               end else begin
                  i_HREADY = 1'b1; i_HRESP = 2'b00;
                  if (!dp_write) i_HRDATA = slave_result();
                  finish_dp();
               end
            end else if (o_HTRANS == 2'b10) begin
               nonseq_cycles++;
               if (stalling && o_HADDR !== stall_addr) unstable_cnt++;
               i_HRESP = 2'b00; i_HRDATA = $urandom;
               if (astall_left > 0) begin
                  i_HREADY = 1'b0; astall_left--; stalling = 1'b1; stall_addr = o_HADDR;
               end else begin
                  i_HREADY = 1'b1; stalling = 1'b0;
                  dp_active = 1'b1; dp_addr = o_HADDR; dp_write = o_HWRITE; dp_first = 1'b1;
                  dp_wait_left = cfg_waits[o_HADDR[3:2]];
                  dp_is_err = (cfg_err_step == int'(o_HADDR[3:2]));
                  dp_err_cnt = 0;
               end
            end else begin
               i_HREADY = 1'b1; i_HRESP = 2'b00; i_HRDATA = $urandom;
            end
         end
      end
   endtask

   // reference model: command-level rules
   function automatic logic [31:0] exp_addr(input logic unit, input int i);
      return (unit ? MUL_BASE : ALU_BASE) + 32'(4 * i);
   endfunction

   function automatic logic [31:0] exp_wdata(input int i, input logic [31:0] a,
                                             input logic [31:0] b, input logic [3:0] op);
      if (i == 0) return a;
      if (i == 1) return b;
      return {28'h0, op};
   endfunction

   function automatic int exp_latency(input logic [7:0] wp, input int err_step, input int astall);
      int last = (err_step >= 0) ? err_step : 3;
      int lat  = astall;
      for (int i = 0; i <= last; i++)
         lat += 2 + ((i == err_step) ? 1 : int'(wp[2*i +: 2]));
      return lat;
   endfunction

   task automatic configure(input logic [7:0] wp, input int err_step, input int astall);
      for (int i = 0; i < 4; i++) cfg_waits[i] = int'(wp[2*i +: 2]);
      cfg_err_step = err_step;
      astall_left  = astall;
      t_addr.delete(); t_write.delete(); t_wdata.delete();
      nonseq_cycles = 0; unstable_cnt = 0; bad_htrans = 0;
   endtask

   task automatic issue(input logic unit, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int n = 0;
      while (n < 50 && cmd_ready !== 1'b1) begin @(posedge HCLK); #2; n++; end
      check("cmd_ready_wait", 32'(n < 50), 32'd1);
      cmd_valid = 1'b1; cmd_unit = unit; cmd_op = op; cmd_a = a; cmd_b = b;
      @(posedge HCLK); #1;
      cmd_valid = 1'b0;
      check("accept_cmd_ready", 32'(cmd_ready), 32'd0);
      check("accept_busy", 32'(busy), 32'd1);
   endtask

   task automatic run_cmd(input logic unit, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [7:0] wp, input int err_step,
                          input int astall, input int bp);
      int lat = 0;
      int last = (err_step >= 0) ? err_step : 3;
      int ns0;
      logic [31:0] rd;
      logic re;
      configure(wp, err_step, astall);
      issue(unit, op, a, b);
      while (lat < 300 && rsp_valid !== 1'b1) begin @(posedge HCLK); #1; lat++; end
      check("latency", 32'(lat), 32'(exp_latency(wp, err_step, astall)));
      check("rsp_err", 32'(rsp_err), 32'(err_step >= 0));
      check("rsp_data", rsp_data, (err_step >= 0) ? 32'h0 : (unit ? a * b : a + b));
      check("n_xfers", 32'(t_addr.size()), 32'(last + 1));
      for (int i = 0; i <= last && i < t_addr.size(); i++) begin
         check("xfer_addr", t_addr[i], exp_addr(unit, i));
         check("xfer_write", 32'(t_write[i]), 32'(i != 3));
         if (i < 3) check("xfer_wdata", t_wdata[i], exp_wdata(i, a, b, op));
      end
      check("nonseq_cycles", 32'(nonseq_cycles), 32'(last + 1 + astall));
      check("unstable", 32'(unstable_cnt), 32'd0);
      check("bad_htrans", 32'(bad_htrans), 32'd0);
      rd = rsp_data; re = rsp_err; ns0 = nonseq_cycles;
      for (int k = 0; k < bp; k++) begin
         cmd_valid = k[0];
         @(posedge HCLK); #1;
         check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
         check("bp_rsp_data", rsp_data, rd);
         check("bp_rsp_err", 32'(rsp_err), 32'(re));
         check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge HCLK); #1;
      rsp_ready = 1'b0;
      check("post_rsp_valid", 32'(rsp_valid), 32'd0);
      check("post_rsp_err", 32'(rsp_err), 32'd0);
      check("post_cmd_ready", 32'(cmd_ready), 32'd1);
      check("post_busy", 32'(busy), 32'd0);
      check("post_no_nonseq", 32'(nonseq_cycles), 32'(ns0));
   endtask

   initial begin
      int n;
      int es;
      cmd_valid = 1'b0; cmd_unit = 1'b0; cmd_op = 4'h0; cmd_a = 32'h0; cmd_b = 32'h0;
      rsp_ready = 1'b0;
      i_HREADY = 1'b1; i_HRESP = 2'b00; i_HRDATA = 32'h0;
      s_a = 32'h0; s_b = 32'h0;
      configure(8'h00, -1, 0);
      fork
         slave_loop();
      join_none

      repeat (3) @(posedge HCLK);
      #1;
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_data", rsp_data, 32'h0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_htrans", 32'(o_HTRANS), 32'd0);
      check("rst_haddr", o_HADDR, 32'h0);
      check("rst_hwdata", o_HWDATA, 32'h0);
      check("rst_hwrite", 32'(o_HWRITE), 32'd0);
      check("hsize", 32'(o_HSIZE), 32'd2);
      check("hburst", 32'(o_HBURST), 32'd0);
      @(posedge HCLK); #2;
      HRESETn = 1'b0;

      // ALU, zero-wait slave: 5 + 7
      run_cmd(1'b0, 4'h1, 32'd5, 32'd7, 8'h00, -1, 0, 0);
      // multiplier, 3 wait states on the result read
      run_cmd(1'b1, 4'h2, 32'h0000_1000, 32'h10, 8'b11_00_00_00, -1, 0, 0);
      // two-cycle ERROR on step 1, then a normal command
      run_cmd(1'b0, 4'h4, 32'd9, 32'd3, 8'h00, 1, 0, 0);
      run_cmd(1'b1, 4'h2, 32'd3, 32'd4, 8'h00, -1, 0, 0);
      // response back-pressure for 5 cycles
      run_cmd(1'b0, 4'h5, 32'h1234_0000, 32'h0000_5678, 8'h00, -1, 0, 5);
      // first address phase stalled for 2 cycles
      run_cmd(1'b1, 4'h7, 32'd6, 32'd9, 8'h00, -1, 2, 0);

      // reset pulse during the opcode-write data phase
      configure(8'b00_11_00_00, -1, 0);
      issue(1'b0, 4'h3, 32'h11, 32'h22);
      n = 0;
      while (n < 100 && !(dp_active && dp_addr[3:2] == 2'd2)) begin @(posedge HCLK); #2; n++; end
      check("rst_mid_reached", 32'(n < 100), 32'd1);
      HRESETn = 1'b1;
      #1;
      check("rst_mid_htrans", 32'(o_HTRANS), 32'd0);
      check("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      @(posedge HCLK); #2;
      HRESETn = 1'b0;
      check("rst_mid_htrans_after", 32'(o_HTRANS), 32'd0);
      run_cmd(1'b0, 4'h1, 32'd100, 32'd23, 8'h00, -1, 0, 0);

      // randomized commands
      for (int r = 0; r < 25; r++) begin
         es = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
         run_cmd(1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom,
                 8'($urandom), es, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
